// File: rtl/wb_stage_pkg.sv
// Shared constants for the RV32I write-back stage: datapath widths,
// write-back source selects and load funct3 encodings.
package wb_stage_pkg;
  localparam int XLEN     = 32;
  localparam int REG_ADDR = 5;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB capture bus, register-file write port and decode bypass signals.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                in_valid;
  logic                stall;
  logic                flush;
  logic                reg_write_in;
  logic [1:0]          wb_sel;
  logic [2:0]          funct3;
  logic [REG_ADDR-1:0] rd;
  logic [XLEN-1:0]     alu_result;
  logic [XLEN-1:0]     mem_rdata;
  logic [XLEN-1:0]     pc_plus4;
  logic                reg_write;
  logic [REG_ADDR-1:0] AddrD;
  logic [XLEN-1:0]     DataD;
  logic [REG_ADDR-1:0] rs1_addr;
  logic [REG_ADDR-1:0] rs2_addr;
  logic [XLEN-1:0]     rf_dataA;
  logic [XLEN-1:0]     rf_dataB;
  logic [XLEN-1:0]     fwd_dataA;
  logic [XLEN-1:0]     fwd_dataB;
  logic [63:0]         instret;

  modport slave (
    input  in_valid, stall, flush, reg_write_in, wb_sel, funct3, rd,
           alu_result, mem_rdata, pc_plus4, rs1_addr, rs2_addr, rf_dataA, rf_dataB,
    output reg_write, AddrD, DataD, fwd_dataA, fwd_dataB, instret
  );

  modport master (
    output in_valid, stall, flush, reg_write_in, wb_sel, funct3, rd,
           alu_result, mem_rdata, pc_plus4, rs1_addr, rs2_addr, rf_dataA, rf_dataB,
    input  reg_write, AddrD, DataD, fwd_dataA, fwd_dataB, instret
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the byte/halfword addressed within the raw word
// and sign- or zero-extends it according to funct3.
module wb_stage_load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (addr_i)
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      2'd3:    byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    // Halfword select ignores addr[0]; misaligned halves are not trapped here.
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (funct3_i)
      LOAD_LB:  data_o = {{24{byte_v[7]}}, byte_v};
      LOAD_LBU: data_o = {24'd0, byte_v};
      LOAD_LH:  data_o = {{16{half_v[15]}}, half_v};
      LOAD_LHU: data_o = {16'd0, half_v};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage: drives the register-file
// write port, bypasses WB data to decode and counts retired instructions.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  wb_stage_if.slave bus
);

  logic                valid_q;
  logic                we_q;
  logic [1:0]          wb_sel_q;
  logic [2:0]          funct3_q;
  logic [REG_ADDR-1:0] rd_q;
  logic [XLEN-1:0]     alu_q;
  logic [XLEN-1:0]     mem_q;
  logic [XLEN-1:0]     pc4_q;
  logic                committed_q;
  logic [63:0]         instret_q;

  logic                fire;
  logic [XLEN-1:0]     load_val;
  logic [XLEN-1:0]     wb_data;
  logic                wr_en;

  assign fire = valid_q & ~committed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      wb_sel_q    <= WB_SEL_ALU;
      funct3_q    <= 3'd0;
      rd_q        <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      pc4_q       <= '0;
      committed_q <= 1'b0;
      instret_q   <= 64'd0;
    end else begin
      if (!bus.stall) begin
        valid_q     <= bus.in_valid & ~bus.flush;
        we_q        <= bus.reg_write_in;
        wb_sel_q    <= bus.wb_sel;
        funct3_q    <= bus.funct3;
        rd_q        <= bus.rd;
        alu_q       <= bus.alu_result;
        mem_q       <= bus.mem_rdata;
        pc4_q       <= bus.pc_plus4;
        committed_q <= 1'b0;
      end else if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (fire) begin
        // A held instruction has already written; block a repeat write.
        committed_q <= 1'b1;
      end
      if (fire) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  wb_stage_load_align u_load_align (
    .funct3_i (funct3_q),
    .addr_i   (alu_q[1:0]),
    .rdata_i  (mem_q),
    .data_o   (load_val)
  );

  always_comb begin
    case (wb_sel_q)
      WB_SEL_MEM: wb_data = load_val;
      WB_SEL_PC4: wb_data = pc4_q;
      default:    wb_data = alu_q;
    endcase
  end

  assign wr_en = fire & we_q & (rd_q != '0);

  assign bus.reg_write = wr_en;
  assign bus.AddrD     = rd_q;
  assign bus.DataD     = wb_data;
  assign bus.instret   = instret_q;

  // wr_en already excludes x0, so x0 is never bypassed.
  assign bus.fwd_dataA = (wr_en && (rd_q == bus.rs1_addr)) ? wb_data : bus.rf_dataA;
  assign bus.fwd_dataB = (wr_en && (rd_q == bus.rs2_addr)) ? wb_data : bus.rf_dataB;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [63:0] exp_ret;

  wb_stage_if bus ();

  wb_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc);
    bus.in_valid     = v;
    bus.reg_write_in = we;
    bus.wb_sel       = sel;
    bus.funct3       = f3;
    bus.rd           = rd;
    bus.alu_result   = alu;
    bus.mem_rdata    = mem;
    bus.pc_plus4     = pc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    bus.rf_dataA = 32'h11;
    bus.rf_dataB = 32'h22;
    #3;
    n_checks++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_reg_write got=%0b exp=0", bus.reg_write); end
    n_checks++; if (bus.AddrD !== 5'd0) begin n_fail++; $display("FAIL reset_AddrD got=%0d exp=0", bus.AddrD); end
    n_checks++; if (bus.DataD !== 32'd0) begin n_fail++; $display("FAIL reset_DataD got=%h exp=0", bus.DataD); end
    n_checks++; if (bus.instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret got=%0d exp=0", bus.instret); end
    n_checks++; if (bus.fwd_dataA !== 32'h11) begin n_fail++; $display("FAIL reset_fwdA got=%h exp=11", bus.fwd_dataA); end
    n_checks++; if (bus.fwd_dataB !== 32'h22) begin n_fail++; $display("FAIL reset_fwdB got=%h exp=22", bus.fwd_dataB); end
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_ret = 64'd0;
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, WB_SEL_ALU, 3'd0, 5'd5, 32'h1234, 32'hDEAD_BEEF, 32'h40);
    tick();
    exp_ret++;
    n_checks++; if (bus.reg_write !== 1'b1) begin n_fail++; $display("FAIL alu_reg_write got=%0b exp=1", bus.reg_write); end
    n_checks++; if (bus.AddrD !== 5'd5) begin n_fail++; $display("FAIL alu_AddrD got=%0d exp=5", bus.AddrD); end
    n_checks++; if (bus.DataD !== 32'h1234) begin n_fail++; $display("FAIL alu_DataD got=%h exp=1234", bus.DataD); end
    n_checks++; if (bus.instret !== 64'd0) begin n_fail++; $display("FAIL alu_instret_pre got=%0d exp=0", bus.instret); end
    drive(1'b0, 1'b0, WB_SEL_ALU, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    n_checks++; if (bus.instret !== 64'd1) begin n_fail++; $display("FAIL alu_instret got=%0d exp=1", bus.instret); end
    n_checks++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL alu_idle_reg_write got=%0b exp=0", bus.reg_write); end
  endtask

  task automatic test_back_to_back_loads();
    logic [1:0]  sel [11] = '{WB_SEL_MEM, WB_SEL_MEM, WB_SEL_MEM, WB_SEL_MEM, WB_SEL_MEM,
                             WB_SEL_MEM, WB_SEL_MEM, WB_SEL_MEM, WB_SEL_MEM, WB_SEL_PC4, 2'b11};
    logic [2:0]  f3  [11] = '{LOAD_LB, LOAD_LBU, LOAD_LHU, LOAD_LH, LOAD_LW,
                             LOAD_LH, LOAD_LB, LOAD_LH, 3'b011, 3'd0, 3'd0};
    logic [31:0] alu [11] = '{32'h1000_0003, 32'h1000_0003, 32'h1000_0002, 32'h1000_0002, 32'h1000_0002,
                             32'h1000_0003, 32'h1000_0001, 32'h1000_0000, 32'h1000_0001, 32'h99, 32'h4321};
    logic [31:0] mem [11] = '{32'h80FF_0000, 32'h80FF_0000, 32'hBEEF_0001, 32'hBEEF_0001, 32'hBEEF_0001,
                             32'hBEEF_0001, 32'h1234_5678, 32'h1234_8765, 32'hCAFE_F00D, 32'h5555_5555, 32'h0};
    logic [31:0] exp [11] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'hBEEF_0001,
                             32'hFFFF_BEEF, 32'h0000_0056, 32'hFFFF_8765, 32'hCAFE_F00D, 32'h0000_1004, 32'h0000_4321};
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b1, sel[i], f3[i], 5'(i + 1), alu[i], mem[i], 32'h1004);
      tick();
      exp_ret++;
      n_checks++; if (bus.DataD !== exp[i]) begin n_fail++; $display("FAIL load_DataD[%0d] got=%h exp=%h", i, bus.DataD, exp[i]); end
      n_checks++; if (bus.AddrD !== 5'(i + 1) || bus.reg_write !== 1'b1) begin
        n_fail++; $display("FAIL load_write[%0d] got AddrD=%0d we=%0b exp AddrD=%0d we=1", i, bus.AddrD, bus.reg_write, i + 1);
      end
    end
    drive(1'b0, 1'b0, WB_SEL_ALU, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    n_checks++; if (bus.instret !== exp_ret) begin n_fail++; $display("FAIL load_instret got=%0d exp=%0d", bus.instret, exp_ret); end
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b1, WB_SEL_ALU, 3'd0, 5'd0, 32'h5A5A, 32'd0, 32'd0);
    bus.rs1_addr = 5'd0;
    bus.rf_dataA = 32'h55;
    tick();
    exp_ret++;
    n_checks++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL x0_reg_write got=%0b exp=0", bus.reg_write); end
    n_checks++; if (bus.fwd_dataA !== 32'h55) begin n_fail++; $display("FAIL x0_fwdA got=%h exp=55", bus.fwd_dataA); end
    drive(1'b0, 1'b0, WB_SEL_ALU, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    n_checks++; if (bus.instret !== exp_ret) begin n_fail++; $display("FAIL x0_instret got=%0d exp=%0d", bus.instret, exp_ret); end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, WB_SEL_ALU, 3'd0, 5'd7, 32'h777, 32'd0, 32'd0);
    tick();
    exp_ret++;
    n_checks++; if (bus.reg_write !== 1'b1 || bus.DataD !== 32'h777) begin
      n_fail++; $display("FAIL stall_first we=%0b data=%h exp we=1 data=777", bus.reg_write, bus.DataD);
    end
    bus.stall = 1'b1;
    drive(1'b1, 1'b1, WB_SEL_ALU, 3'd0, 5'd3, 32'h333, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.reg_write !== 1'b0 || bus.AddrD !== 5'd7) begin
        n_fail++; $display("FAIL stall_hold[%0d] we=%0b AddrD=%0d exp we=0 AddrD=7", i, bus.reg_write, bus.AddrD);
      end
    end
    n_checks++; if (bus.instret !== exp_ret) begin n_fail++; $display("FAIL stall_instret got=%0d exp=%0d", bus.instret, exp_ret); end
    bus.stall = 1'b0;
    drive(1'b0, 1'b0, WB_SEL_ALU, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    n_checks++; if (bus.instret !== exp_ret || bus.reg_write !== 1'b0) begin
      n_fail++; $display("FAIL stall_release instret=%0d we=%0b exp instret=%0d we=0", bus.instret, bus.reg_write, exp_ret);
    end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    drive(1'b1, 1'b1, WB_SEL_ALU, 3'd0, 5'd8, 32'h888, 32'd0, 32'd0);
    tick();
    n_checks++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_capture got=%0b exp=0", bus.reg_write); end
    bus.stall = 1'b1;
    tick();
    n_checks++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_stall got=%0b exp=0", bus.reg_write); end
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, WB_SEL_ALU, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    n_checks++; if (bus.instret !== exp_ret) begin n_fail++; $display("FAIL flush_instret got=%0d exp=%0d", bus.instret, exp_ret); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b1, WB_SEL_ALU, 3'd0, 5'd9, 32'hAA, 32'd0, 32'd0);
    bus.rs1_addr = 5'd9;
    bus.rs2_addr = 5'd9;
    bus.rf_dataA = 32'd0;
    bus.rf_dataB = 32'd0;
    tick();
    exp_ret++;
    n_checks++; if (bus.fwd_dataA !== 32'hAA) begin n_fail++; $display("FAIL bypass_A got=%h exp=aa", bus.fwd_dataA); end
    n_checks++; if (bus.fwd_dataB !== 32'hAA) begin n_fail++; $display("FAIL bypass_B got=%h exp=aa", bus.fwd_dataB); end
    bus.rs2_addr = 5'd10;
    bus.rf_dataB = 32'h77;
    #1;
    n_checks++; if (bus.fwd_dataB !== 32'h77) begin n_fail++; $display("FAIL bypass_B_miss got=%h exp=77", bus.fwd_dataB); end
    drive(1'b0, 1'b0, WB_SEL_ALU, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    tick();
    n_checks++; if (bus.fwd_dataA !== 32'd0) begin n_fail++; $display("FAIL bypass_A_idle got=%h exp=0", bus.fwd_dataA); end
    n_checks++; if (bus.instret !== exp_ret) begin n_fail++; $display("FAIL bypass_instret got=%0d exp=%0d", bus.instret, exp_ret); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, WB_SEL_ALU, 3'd0, 5'd7, 32'h7070, 32'd0, 32'd0);
    tick();
    bus.stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.reg_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_reg_write got=%0b exp=0", bus.reg_write); end
    n_checks++; if (bus.instret !== 64'd0) begin n_fail++; $display("FAIL rstmid_instret got=%0d exp=0", bus.instret); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.reg_write !== 1'b0 || bus.instret !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_after we=%0b instret=%0d exp we=0 instret=0", bus.reg_write, bus.instret);
    end
    bus.stall = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_ret  = 64'd0;
    test_reset();
    test_alu();
    test_back_to_back_loads();
    test_x0();
    test_stall();
    test_flush();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
